// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one shared full_adder cell adds two WIDTH-bit
// operands LSB first, one bit per clock, with start/busy/done handshake.

module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] ps;
    logic [WIDTH-1:0] ps_shift;
    logic [CW-1:0]    cnt;
    logic             c;
    logic             fa_s;
    logic             fa_co;
    logic             load;
    logic             last;

    full_adder u_fa (
        .x  (sa[0]),
        .y  (sb[0]),
        .ci (c),
        .s  (fa_s),
        .co (fa_co)
    );

    // New bit enters at the MSB; after WIDTH shifts bit 0 of the sum sits at ps[0].
    assign ps_shift = WIDTH'({fa_s, ps} >> 1);
    assign load     = start && (state == IDLE || state == DONE);
    assign last     = (state == RUN) && (cnt == LAST);
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa   <= '0;
            sb   <= '0;
            ps   <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
        end else if (load) begin
            sa  <= a;
            sb  <= b;
            c   <= cin;
            cnt <= '0;
        end else if (state == RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            c   <= fa_co;
            ps  <= ps_shift;
            cnt <= cnt + CW'(1);
            if (last) begin
                sum  <= ps_shift;
                cout <= fa_co;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl at WIDTH=8 and WIDTH=1.

module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start1 = 1'b0;
    logic       a1 = 1'b0;
    logic       b1 = 1'b0;
    logic       cin1 = 1'b0;
    logic       busy1;
    logic       done1;
    logic       sum1;
    logic       cout1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Runs one operation; optionally pokes start and new operands at cycle poke_at of RUN.
    task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                          input int poke_at,
                          output logic [7:0] rs, output logic rc,
                          output int done_at, output int busy_cnt,
                          output int done_cnt, output int both);
        @(negedge clk);
        a = va; b = vb; cin = vc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_at = 0; busy_cnt = 0; done_cnt = 0; both = 0; rs = '0; rc = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) @(negedge clk);
            if (k == poke_at) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
            end else if (k == poke_at + 1) begin
                start = 1'b0;
            end
            if (busy) busy_cnt++;
            if (busy && done) both++;
            if (done) begin
                done_cnt++;
                if (done_at == 0) begin
                    done_at = k; rs = sum; rc = cout;
                end
            end
        end
    endtask

    initial begin
        vec_t vecs[6];
        logic [7:0] rs;
        logic       rc;
        int         done_at, busy_cnt, done_cnt, both;
        int         d1, d2, extra_done;
        logic [8:0] ref9;
        logic [1:0] ref2;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

        #2;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_sum", sum, 0);
        check("reset_cout", cout, 0);
        check("reset_w1_outs", {busy1, done1, sum1, cout1}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 0, rs, rc, done_at, busy_cnt, done_cnt, both);
            check($sformatf("vec%0d_sum", i), rs, vecs[i].sum);
            check($sformatf("vec%0d_cout", i), rc, vecs[i].cout);
            check($sformatf("vec%0d_done_at", i), done_at, 9);
            check($sformatf("vec%0d_busy_cycles", i), busy_cnt, 8);
            check($sformatf("vec%0d_done_count", i), done_cnt, 1);
            check($sformatf("vec%0d_busy_and_done", i), both, 0);
        end

        // start pulse and operand change during RUN must be ignored
        run_op(8'h12, 8'h34, 1'b0, 3, rs, rc, done_at, busy_cnt, done_cnt, both);
        check("ignore_sum", rs, 8'h46);
        check("ignore_cout", rc, 0);
        check("ignore_done_at", done_at, 9);
        check("ignore_done_count", done_cnt, 1);

        // start held high across two operations
        @(negedge clk);
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        d1 = 0; d2 = 0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (done) begin
                if (d1 == 0) begin
                    d1 = k;
                    check("held_first_sum", sum, 8'h03);
                    a = 8'h10; b = 8'h20;
                end else if (d2 == 0) begin
                    d2 = k;
                    check("held_second_sum", sum, 8'h30);
                    start = 1'b0;
                end
            end else if (d1 != 0 && d2 == 0 && k == d1 + 4) begin
                check("held_sum_hold_in_run", sum, 8'h03);
                check("held_busy_in_second_run", busy, 1);
            end
        end
        start = 1'b0;
        check("held_first_done_at", d1, 9);
        check("held_done_spacing", d2 - d1, 9);

        // reset in the middle of RUN
        @(negedge clk);
        a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        check("midreset_sum", sum, 0);
        check("midreset_cout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        extra_done = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || busy) extra_done++;
        end
        check("no_done_after_reset", extra_done, 0);
        run_op(8'hC3, 8'h3D, 1'b1, 0, rs, rc, done_at, busy_cnt, done_cnt, both);
        check("post_reset_sum", rs, 8'h01);
        check("post_reset_cout", rc, 1);
        check("post_reset_done_at", done_at, 9);

        // random regression, WIDTH=8
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra, rb;
            logic       rcin;
            ra = 8'($urandom); rb = 8'($urandom); rcin = 1'($urandom);
            ref9 = {1'b0, ra} + {1'b0, rb} + {8'b0, rcin};
            run_op(ra, rb, rcin, 0, rs, rc, done_at, busy_cnt, done_cnt, both);
            check($sformatf("rand8_%0d_%0h_%0h_%0h", i, ra, rb, rcin), {done_at[3:0], rc, rs},
                  {4'd9, ref9});
        end

        // random regression, WIDTH=1: busy one cycle, done the next
        for (int i = 0; i < 1000; i++) begin
            logic ra, rb, rcin;
            ra = 1'($urandom); rb = 1'($urandom); rcin = 1'($urandom);
            ref2 = {1'b0, ra} + {1'b0, rb} + {1'b0, rcin};
            @(negedge clk);
            a1 = ra; b1 = rb; cin1 = rcin; start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            if (i < 4) check($sformatf("w1_busy_%0d", i), {busy1, done1}, 2'b10);
            @(negedge clk);
            check($sformatf("rand1_%0d_%0b%0b%0b", i, ra, rb, rcin), {busy1, done1, cout1, sum1},
                  {2'b01, ref2});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
